// File: rtl/axi_slave_mem_if.sv
// AXI4 bus bundle between a master and the axi_slave_mem endpoint.
// The master modport drives requests and write data; the slave modport drives readies and responses.
interface axi_slave_mem_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int ID_WIDTH   = 8
);
   logic [ID_WIDTH-1:0]   awid;
   logic [ADDR_WIDTH-1:0] awaddr;
   logic [7:0]            awlen;
   logic [2:0]            awsize;
   logic [1:0]            awburst;
   logic                  awlock;
   logic [3:0]            awcache;
   logic [2:0]            awprot;
   logic                  awvalid;
   logic                  awready;

   logic [ID_WIDTH-1:0]   wid;
   logic [DATA_WIDTH-1:0] wdata;
   logic [STRB_WIDTH-1:0] wstrb;
   logic                  wlast;
   logic                  wvalid;
   logic                  wready;

   logic [ID_WIDTH-1:0]   bid;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;

   logic [ID_WIDTH-1:0]   arid;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [7:0]            arlen;
   logic [2:0]            arsize;
   logic [1:0]            arburst;
   logic                  arlock;
   logic [3:0]            arcache;
   logic [2:0]            arprot;
   logic                  arvalid;
   logic                  arready;

   logic [ID_WIDTH-1:0]   rid;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rlast;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      input  awready,
      output wid, wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready,
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      output awready,
      input  wid, wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready,
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );
endinterface

// File: rtl/axi_slave_mem.sv
// AXI4 slave memory: independent write and read FSMs, one outstanding burst per direction,
// FIXED/INCR/WRAP addressing, byte strobes, SLVERR on illegal bursts or wlast mismatch.
module axi_slave_mem #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int ID_WIDTH   = 8
) (
   input  logic           clk,
   input  logic           reset,
   axi_slave_mem_if.slave axi
);
   localparam int LANE_BITS = $clog2(STRB_WIDTH);
   localparam int DEPTH     = 1 << (ADDR_WIDTH - LANE_BITS);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

   function automatic logic burst_err(input logic [1:0] burst, input logic [2:0] size,
                                      input logic [7:0] len);
      return (burst == 2'b11) || (size > 3'(LANE_BITS)) ||
             ((burst == 2'b10) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
   endfunction

   function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                       input logic [7:0] len,
                                                       input logic [2:0] size,
                                                       input logic [1:0] burst);
      logic [ADDR_WIDTH-1:0] step, aligned, wmask, nxt;
      step    = ADDR_WIDTH'(1) << size;
      aligned = addr & ~(step - ADDR_WIDTH'(1));
      // WRAP window is (len+1) beats of 2^size bytes, aligned to its own size.
      wmask   = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
      case (burst)
         2'b01:   nxt = aligned + step;
         2'b10:   nxt = (addr & ~wmask) | ((aligned + step) & wmask);
         default: nxt = addr;
      endcase
      return nxt;
   endfunction

   function automatic logic [ADDR_WIDTH-LANE_BITS-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
      return addr[ADDR_WIDTH-1:LANE_BITS];
   endfunction

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   w_state_t              w_state, w_next;
   r_state_t              r_state, r_next;
   logic                  run;
   logic [ID_WIDTH-1:0]   w_id, r_id;
   logic [ADDR_WIDTH-1:0] w_addr, r_addr, r_addr_next;
   logic [7:0]            w_len, w_cnt, r_len, r_cnt;
   logic [2:0]            w_size, r_size;
   logic [1:0]            w_burst, r_burst;
   logic                  w_err, r_err, ar_err;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  awready, wready, bvalid, arready, rvalid;
   logic                  aw_hs, w_hs, ar_hs, r_hs, beat_err, wr_en, r_last;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         w_state <= W_IDLE;
         r_state <= R_IDLE;
         run     <= 1'b0;
      end else begin
         w_state <= w_next;
         r_state <= r_next;
         run     <= 1'b1;
      end
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      w_next  = w_state;
      awready = 1'b0;
      wready  = 1'b0;
      bvalid  = 1'b0;
      case (w_state)
         W_IDLE: begin
            awready = run;
            if (run && axi.awvalid) w_next = W_DATA;
         end
         W_DATA: begin
            wready = 1'b1;
            if (axi.wvalid && (w_cnt == w_len)) w_next = W_RESP;
         end
         W_RESP: begin
            bvalid = 1'b1;
            if (axi.bready) w_next = W_IDLE;
         end
         default: w_next = W_IDLE;
      endcase
   end

   always_comb begin
      r_next  = r_state;
      arready = 1'b0;
      rvalid  = 1'b0;
      case (r_state)
         R_IDLE: begin
            arready = run;
            if (run && axi.arvalid) r_next = R_DATA;
         end
         R_DATA: begin
            rvalid = 1'b1;
            if (axi.rready && r_last) r_next = R_IDLE;
         end
         default: r_next = R_IDLE;
      endcase
   end

   assign aw_hs       = awready && axi.awvalid;
   assign w_hs        = wready && axi.wvalid;
   assign ar_hs       = arready && axi.arvalid;
   assign r_hs        = rvalid && axi.rready;
   assign r_last      = (r_cnt == r_len);
   assign ar_err      = burst_err(axi.arburst, axi.arsize, axi.arlen);
   assign beat_err    = axi.wlast != (w_cnt == w_len);
   assign wr_en       = reset && w_hs && !w_err && !beat_err;
   assign r_addr_next = next_addr(r_addr, r_len, r_size, r_burst);

   always_ff @(posedge clk) begin
      if (!reset) begin
         w_id    <= '0;
         w_addr  <= '0;
         w_len   <= '0;
         w_size  <= '0;
         w_burst <= '0;
         w_cnt   <= '0;
         w_err   <= 1'b0;
         r_id    <= '0;
         r_addr  <= '0;
         r_len   <= '0;
         r_size  <= '0;
         r_burst <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
         rdata_q <= '0;
      end else begin
         if (aw_hs) begin
            w_id    <= axi.awid;
            w_addr  <= axi.awaddr;
            w_len   <= axi.awlen;
            w_size  <= axi.awsize;
            w_burst <= axi.awburst;
            w_cnt   <= '0;
            w_err   <= burst_err(axi.awburst, axi.awsize, axi.awlen);
         end else if (w_hs) begin
            w_cnt  <= w_cnt + 8'd1;
            w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
            if (beat_err) w_err <= 1'b1;
         end

         // Read data is prefetched one beat ahead so it is valid on the cycle rvalid rises.
         if (ar_hs) begin
            r_id    <= axi.arid;
            r_addr  <= axi.araddr;
            r_len   <= axi.arlen;
            r_size  <= axi.arsize;
            r_burst <= axi.arburst;
            r_cnt   <= '0;
            r_err   <= ar_err;
            rdata_q <= ar_err ? '0 : mem[word_idx(axi.araddr)];
         end else if (r_hs && !r_last) begin
            r_cnt   <= r_cnt + 8'd1;
            r_addr  <= r_addr_next;
            rdata_q <= r_err ? '0 : mem[word_idx(r_addr_next)];
         end
      end
   end

   // NOTE: the storage array has no reset; its contents must survive a reset pulse.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < STRB_WIDTH; i++) begin
            if (axi.wstrb[i]) mem[word_idx(w_addr)][8*i +: 8] <= axi.wdata[8*i +: 8];
         end
      end
   end

   assign axi.awready = awready;
   assign axi.wready  = wready;
   assign axi.bvalid  = bvalid;
   assign axi.bid     = w_id;
   assign axi.bresp   = (bvalid && w_err) ? RESP_SLVERR : RESP_OKAY;
   assign axi.arready = arready;
   assign axi.rvalid  = rvalid;
   assign axi.rid     = r_id;
   assign axi.rdata   = rdata_q;
   assign axi.rresp   = (rvalid && r_err) ? RESP_SLVERR : RESP_OKAY;
   assign axi.rlast   = rvalid && r_last;

   logic unused_inputs;
   assign unused_inputs = &{1'b0, axi.wid, axi.awlock, axi.awcache, axi.awprot,
                            axi.arlock, axi.arcache, axi.arprot};
endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem: a byte-array model predicts B and R responses per burst,
// a negedge monitor compares every valid response cycle, and literal readbacks pin the model.
module tb_axi_slave_mem;
   localparam int DW = 32;
   localparam int AW = 16;
   localparam int IW = 8;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
      logic [7:0]  id;
   } rbeat_t;

   typedef struct {
      logic [7:0] id;
      logic [1:0] resp;
   } bexp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   axi_slave_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) axi ();

   axi_slave_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
      .clk  (clk),
      .reset(reset),
      .axi  (axi)
   );

   int          vectors = 0;
   int          miscompares = 0;
   rbeat_t      exp_r[$];
   bexp_t       exp_b[$];
   logic [7:0]  mbytes [65536];
   logic [31:0] wbuf [16];
   logic [3:0]  sbuf [16];
   logic [31:0] got[$];
   logic [7:0]  last_bid;
   logic [1:0]  last_bresp;
   logic [1:0]  last_rresp;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic model_err(input logic [1:0] burst, input logic [2:0] size,
                                      input logic [7:0] len);
      return burst == 2'b11 || size > 3'd2 ||
             (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
   endfunction

   // Byte address of beat i, computed directly from the burst start rather than stepwise.
   function automatic int beat_addr(input logic [15:0] start, input logic [7:0] len,
                                    input logic [2:0] size, input logic [1:0] burst, input int i);
      int nb, wb, base, a;
      nb = 1 << size;
      case (burst)
         2'b01: a = (i == 0) ? int'(start) : (int'(start) / nb) * nb + i * nb;
         2'b10: begin
            wb   = (int'(len) + 1) * nb;
            base = (int'(start) / wb) * wb;
            a    = base + ((int'(start) - base + i * nb) % wb);
         end
         default: a = int'(start);
      endcase
      return a & 16'hFFFF;
   endfunction

   always @(negedge clk) begin
      if (reset) begin
         if (axi.rvalid) begin
            check("r_expected", 64'(exp_r.size() != 0), 64'd1);
            if (exp_r.size() != 0) begin
               check("rdata", axi.rdata, exp_r[0].data);
               check("rresp", axi.rresp, exp_r[0].resp);
               check("rlast", axi.rlast, exp_r[0].last);
               check("rid", axi.rid, exp_r[0].id);
               last_rresp = axi.rresp;
               if (axi.rready) void'(exp_r.pop_front());
            end
         end
         if (axi.bvalid && axi.bready) begin
            check("b_expected", 64'(exp_b.size() != 0), 64'd1);
            if (exp_b.size() != 0) begin
               check("bid", axi.bid, exp_b[0].id);
               check("bresp", axi.bresp, exp_b[0].resp);
               void'(exp_b.pop_front());
            end
            last_bid   = axi.bid;
            last_bresp = axi.bresp;
         end
      end
   end

   task automatic write_burst(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst, input int bad_beat);
      logic err;
      int   a, n;
      err = model_err(burst, size, len);
      for (int i = 0; i <= int'(len); i++) begin
         if (i == bad_beat) err = 1'b1;
         if (!err) begin
            a = beat_addr(addr, len, size, burst, i) & ~3;
            for (int j = 0; j < 4; j++) if (sbuf[i][j]) mbytes[a + j] = wbuf[i][8*j +: 8];
         end
      end
      exp_b.push_back('{id: id, resp: err ? 2'b10 : 2'b00});

      axi.awid = id; axi.awaddr = addr; axi.awlen = len; axi.awsize = size; axi.awburst = burst;
      axi.awvalid = 1'b1;
      n = 0;
      while (!axi.awready && n < 50) begin @(negedge clk); n++; end
      check("aw_accept", axi.awready, 1);
      @(posedge clk); #1;
      axi.awvalid = 1'b0;
      @(negedge clk);
      check("wready_after_aw", axi.wready, 1);
      check("awready_busy", axi.awready, 0);
      for (int i = 0; i <= int'(len); i++) begin
         axi.wdata = wbuf[i]; axi.wstrb = sbuf[i];
         axi.wlast = (i == int'(len)) ^ (i == bad_beat);
         axi.wvalid = 1'b1;
         n = 0;
         while (!axi.wready && n < 50) begin @(negedge clk); n++; end
         check("w_accept", axi.wready, 1);
         @(posedge clk); #1;
      end
      axi.wvalid = 1'b0; axi.wlast = 1'b0;
      axi.bready = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!axi.bvalid && n < 50);
      check("b_valid", axi.bvalid, 1);
      @(posedge clk); #1;
      axi.bready = 1'b0;
      @(negedge clk);
      check("awready_after_b", axi.awready, 1);
   endtask

   task automatic read_burst(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input bit toggle,
                             input int abort_after);
      logic err;
      int   a, n, cyc;
      got.delete();
      err = model_err(burst, size, len);
      for (int i = 0; i <= int'(len); i++) begin
         a = beat_addr(addr, len, size, burst, i) & ~3;
         exp_r.push_back('{data: err ? 32'h0 : {mbytes[a+3], mbytes[a+2], mbytes[a+1], mbytes[a]},
                           resp: err ? 2'b10 : 2'b00, last: (i == int'(len)), id: id});
      end

      axi.arid = id; axi.araddr = addr; axi.arlen = len; axi.arsize = size; axi.arburst = burst;
      axi.arvalid = 1'b1;
      n = 0;
      while (!axi.arready && n < 50) begin @(negedge clk); n++; end
      check("ar_accept", axi.arready, 1);
      @(posedge clk); #1;
      axi.arvalid = 1'b0;
      cyc = 0;
      while (got.size() <= int'(len) && cyc < 400 &&
             !(abort_after >= 0 && got.size() == abort_after)) begin
         axi.rready = toggle ? (cyc % 2 == 1) : 1'b1;
         @(negedge clk);
         if (axi.rvalid && axi.rready) got.push_back(axi.rdata);
         @(posedge clk); #1;
         cyc++;
      end
      axi.rready = 1'b0;

      if (abort_after >= 0) begin
         reset = 1'b0;
         @(posedge clk); #1;
         exp_r.delete();
         @(negedge clk);
         check("abort_rvalid", axi.rvalid, 0);
         check("abort_rdata", axi.rdata, 0);
         check("abort_arready", axi.arready, 0);
         @(posedge clk); #1;
         reset = 1'b1;
         @(posedge clk);
         @(negedge clk);
         check("arready_after_release", axi.arready, 1);
         check("awready_after_release", axi.awready, 1);
      end else begin
         check("r_beats", got.size(), int'(len) + 1);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, miscompares=%0d", miscompares);
      $fatal(1, "watchdog expired");
   end

   initial begin
      axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0;
      axi.awlock = 1'b0; axi.awcache = '0; axi.awprot = '0; axi.awvalid = 1'b0;
      axi.wid = '0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0;
      axi.bready = 1'b0;
      axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0; axi.arburst = '0;
      axi.arlock = 1'b0; axi.arcache = '0; axi.arprot = '0; axi.arvalid = 1'b0;
      axi.rready = 1'b0;
      reset = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_awready", axi.awready, 0);
      check("rst_arready", axi.arready, 0);
      check("rst_wready", axi.wready, 0);
      check("rst_bvalid", axi.bvalid, 0);
      check("rst_rvalid", axi.rvalid, 0);
      check("rst_rdata", axi.rdata, 0);
      check("rst_bid", axi.bid, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check("awready_before_first_edge", axi.awready, 0);
      @(negedge clk);
      check("awready_after_reset", axi.awready, 1);
      check("arready_after_reset", axi.arready, 1);

      // Single-beat write and readback.
      wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
      write_burst(8'h5A, 16'h0010, 8'd0, 3'd2, 2'b01, -1);
      check("t1_bid", last_bid, 8'h5A);
      check("t1_bresp", last_bresp, 2'b00);
      read_burst(8'h3C, 16'h0010, 8'd0, 3'd2, 2'b01, 1'b0, -1);
      check("t1_rdata", got[0], 32'hDEADBEEF);

      // INCR burst, read back with rready toggling.
      for (int i = 0; i < 4; i++) begin wbuf[i] = 32'(i + 1); sbuf[i] = 4'hF; end
      write_burst(8'h11, 16'h0100, 8'd3, 3'd2, 2'b01, -1);
      read_burst(8'h22, 16'h0100, 8'd3, 3'd2, 2'b01, 1'b1, -1);
      for (int i = 0; i < 4; i++) check("t2_incr_rdata", got[i], 32'(i + 1));

      // WRAP burst starting mid-window, then FIXED burst.
      for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hA0A0_0001 + 32'(i); sbuf[i] = 4'hF; end
      write_burst(8'h33, 16'h0108, 8'd3, 3'd2, 2'b10, -1);
      read_burst(8'h44, 16'h0100, 8'd3, 3'd2, 2'b01, 1'b0, -1);
      check("t3_wrap_0x100", got[0], 32'hA0A0_0003);
      check("t3_wrap_0x104", got[1], 32'hA0A0_0004);
      check("t3_wrap_0x108", got[2], 32'hA0A0_0001);
      check("t3_wrap_0x10c", got[3], 32'hA0A0_0002);
      read_burst(8'h45, 16'h0108, 8'd3, 3'd2, 2'b10, 1'b1, -1);
      check("t3_wrap_read_beat2", got[2], 32'hA0A0_0003);
      for (int i = 0; i < 4; i++) begin wbuf[i] = 32'h11 * 32'(i + 1); sbuf[i] = 4'hF; end
      write_burst(8'h55, 16'h0200, 8'd3, 3'd2, 2'b00, -1);
      read_burst(8'h56, 16'h0200, 8'd0, 3'd2, 2'b01, 1'b0, -1);
      check("t3_fixed", got[0], 32'h44);

      // Byte strobes.
      wbuf[0] = 32'hFFFF_FFFF; sbuf[0] = 4'hF;
      write_burst(8'h60, 16'h0280, 8'd0, 3'd2, 2'b01, -1);
      wbuf[0] = 32'h0000_0000; sbuf[0] = 4'b0101;
      write_burst(8'h61, 16'h0280, 8'd0, 3'd2, 2'b01, -1);
      read_burst(8'h62, 16'h0280, 8'd0, 3'd2, 2'b01, 1'b0, -1);
      check("t4_strobe", got[0], 32'hFF00FF00);

      // Error bursts leave memory untouched.
      wbuf[0] = 32'h1234_5678; sbuf[0] = 4'hF;
      write_burst(8'h70, 16'h0300, 8'd0, 3'd2, 2'b01, -1);
      wbuf[0] = 32'hBAD0_0001; wbuf[1] = 32'hBAD0_0002; wbuf[2] = 32'hBAD0_0003;
      sbuf[0] = 4'hF; sbuf[1] = 4'hF; sbuf[2] = 4'hF;
      write_burst(8'h71, 16'h0300, 8'd0, 3'd2, 2'b11, -1);
      check("t5_reserved_burst_bresp", last_bresp, 2'b10);
      write_burst(8'h72, 16'h0300, 8'd2, 3'd2, 2'b10, -1);
      check("t5_wrap_len2_bresp", last_bresp, 2'b10);
      write_burst(8'h73, 16'h0300, 8'd1, 3'd2, 2'b01, 0);
      check("t5_early_wlast_bresp", last_bresp, 2'b10);
      check("t5_early_wlast_bid", last_bid, 8'h73);
      read_burst(8'h74, 16'h0300, 8'd0, 3'd2, 2'b01, 1'b0, -1);
      check("t5_mem_unchanged", got[0], 32'h1234_5678);
      read_burst(8'h75, 16'h0300, 8'd1, 3'd3, 2'b01, 1'b0, -1);
      check("t5_bad_size_rdata0", got[0], 32'h0);
      check("t5_bad_size_rdata1", got[1], 32'h0);
      check("t5_bad_size_rresp", last_rresp, 2'b10);

      // Reset in the middle of an 8-beat read, then a clean re-read.
      for (int i = 0; i < 8; i++) begin wbuf[i] = 32'hC0DE_0000 + 32'(i); sbuf[i] = 4'hF; end
      write_burst(8'h80, 16'h0400, 8'd7, 3'd2, 2'b01, -1);
      read_burst(8'h81, 16'h0400, 8'd7, 3'd2, 2'b01, 1'b0, 3);
      read_burst(8'h82, 16'h0400, 8'd7, 3'd2, 2'b01, 1'b0, -1);
      check("t6_reread_first", got[0], 32'hC0DE_0000);
      check("t6_reread_last", got[7], 32'hC0DE_0007);
      read_burst(8'h83, 16'h0010, 8'd0, 3'd2, 2'b01, 1'b0, -1);
      check("t6_old_contents", got[0], 32'hDEADBEEF);

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/axi_slave_mem.md
# axi_slave_mem

AXI4 slave memory model that terminates the master-side AXI bus driven by the bench's master clocking block. It accepts write and read bursts (FIXED/INCR/WRAP) on independent channels, stores data in an internal word array with byte strobes, and returns B and R responses with the originating ID. It is the default DUT/endpoint for the AXI bench and the reference target for the responder scoreboard.

## Interface
- DATA_WIDTH, 32, data bus width in bits (8·2^n)
- ADDR_WIDTH, 16, byte address width
- STRB_WIDTH, DATA_WIDTH/8, byte lanes
- ID_WIDTH, 8, transaction ID width
- clk  input  1  single clock; all logic on posedge
- reset  input  1  synchronous, active-low reset
- awid/awaddr/awlen/awsize/awburst  input  ID_WIDTH/ADDR_WIDTH/8/3/2  write address payload
- awlock/awcache/awprot  input  1/4/3  accepted, ignored
- awvalid input 1, awready output 1  AW handshake
- wid  input  ID_WIDTH  ignored (AXI4)
- wdata/wstrb/wlast  input  DATA_WIDTH/STRB_WIDTH/1  write data payload
- wvalid input 1, wready output 1  W handshake
- bid/bresp  output  ID_WIDTH/2  write response; bvalid output 1, bready input 1
- arid/araddr/arlen/arsize/arburst  input  ID_WIDTH/ADDR_WIDTH/8/3/2  read address payload
- arlock/arcache/arprot  input  1/4/3  accepted, ignored
- arvalid input 1, arready output 1  AR handshake
- rid/rdata/rresp/rlast  output  ID_WIDTH/DATA_WIDTH/2/1  read data payload; rvalid output 1, rready input 1

## Operation
- Memory: 2^(ADDR_WIDTH−log2 STRB_WIDTH) words; word index = addr[ADDR_WIDTH−1:log2 STRB_WIDTH]. Contents not cleared by reset.
- Write FSM W_IDLE→W_DATA→W_RESP→W_IDLE. W_IDLE: awready=1; on AW handshake latch id, addr, len, size, burst, clear beat count. W_DATA: wready=1; each W handshake writes bytes with wstrb[i]=1, then advances address. Leave W_DATA on beat count == len. W_RESP: bvalid=1, bid=latched awid, hold until bready.
- Read FSM R_IDLE→R_DATA→R_IDLE. R_IDLE: arready=1; on AR handshake latch fields, register first word into rdata. R_DATA: rvalid=1; on R handshake load next word or, if rlast, return to R_IDLE. rlast=1 on beat count == len. rid=latched arid.
- Address update (width ADDR_WIDTH, wraps modulo 2^ADDR_WIDTH): FIXED(00) unchanged; INCR(01) addr+2^size, aligned down to size after first beat; WRAP(10) increment within boundary of (len+1)·2^size aligned block.
- Errors → SLVERR (2'b10), else OKAY (00): burst=11; size>log2 STRB_WIDTH; WRAP with len∉{1,3,7,15}; wlast value disagreeing with beat count on any beat. Error bursts perform no memory writes / return rdata=0, but complete the full handshake (all len+1 beats).
- Burst length set by awlen only; wlast used solely for error check.
- Channels independent; simultaneous write and read to same word in same cycle: read returns pre-write data.

## Timing
- During reset (reset=0 at posedge): all outputs 0, FSMs to idle. awready/arready go 1 on the first posedge with reset=1.
- Reset asserted mid-burst: burst abandoned, next cycle all outputs 0, no response issued.
- AW handshake at edge N → wready=1 from N+1; last W beat at edge M → bvalid=1 from M+1; B handshake at K → awready=1 from K+1. Single-beat write min cycle: 3 clocks AW-to-AW.
- AR handshake at N → rvalid=1, first rdata valid from N+1. Back-to-back beats at one per clock while rready=1; payload stable while rvalid=1 and rready=0.
- awready=0 outside W_IDLE, arready=0 outside R_IDLE (one outstanding transaction per direction).

## Test plan
- Single write awaddr=0x0010, awlen=0, wdata=0xDEADBEEF, wstrb=4'hF, awid=8'h5A → bresp=00, bid=0x5A; read same address → rdata=0xDEADBEEF, rlast=1, rid=arid.
- INCR write len=3 at 0x0100 data 1..4, then INCR read len=3 with rready toggled every other cycle → rdata 1,2,3,4 in order, held stable while rready=0, rlast on 4th.
- WRAP len=3 size=2 at 0x0108 → beats touch 0x108,0x10C,0x100,0x104; FIXED len=3 at 0x200 → only last beat's data remains.
- Strobe test: write 0xFFFFFFFF then 0x00000000 with wstrb=4'b0101 → readback 0xFF00FF00.
- Error cases: awburst=11, WRAP len=2, early wlast → bresp=10, memory unchanged; arsize=3 (DATA_WIDTH=32) → rresp=10 on all beats, rdata=0.
- Reset pulse during 8-beat read at beat 3 → rvalid=0 next cycle, arready=1 after release; subsequent read completes normally with prior memory contents intact.
